// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch/jump flush
// control and two saturating hazard counters for performance monitoring.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic             ValidD,
    input  logic             PCSrcE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ValidE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] lwstall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            reg_write;
        logic            mem_write;
        logic            alu_src;
        logic            jump;
        logic            branch;
        logic            valid;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
    } ex_bundle_t;

    ex_bundle_t       bundle_d, bundle_q;
    logic [CNT_W-1:0] lwstall_cnt_d, lwstall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic             lw_stall;
    logic             lw_stall_eff;
    logic             flush_e;

    // Hazard detection; the rs1/rs2 match is deliberately conservative and a
    // taken branch/jump in Execute overrides the stall so the front end redirects.
    always_comb begin
        lw_stall     = (bundle_q.result_src == 2'b01) && (bundle_q.rd != 5'd0) &&
                       ((bundle_q.rd == Rs1D) || (bundle_q.rd == Rs2D));
        lw_stall_eff = lw_stall & ~PCSrcE;
        flush_e      = lw_stall | PCSrcE;
    end

    // Next pipeline contents: capture Decode, or insert an all-zero bubble.
    always_comb begin
        bundle_d = '0;
        if (!flush_e) begin
            bundle_d.rs1         = Rs1D;
            bundle_d.rs2         = Rs2D;
            bundle_d.rd          = RdD;
            bundle_d.rd1         = RD1D;
            bundle_d.rd2         = RD2D;
            bundle_d.imm         = ImmExtD;
            bundle_d.pc          = PCD;
            bundle_d.pc_plus4    = PCPlus4D;
            bundle_d.reg_write   = RegWriteD;
            bundle_d.mem_write   = MemWriteD;
            bundle_d.alu_src     = ALUSrcD;
            bundle_d.jump        = JumpD;
            bundle_d.branch      = BranchD;
            bundle_d.valid       = ValidD;
            bundle_d.result_src  = ResultSrcD;
            bundle_d.alu_control = ALUControlD;
        end
    end

    // Saturating hazard counters.
    always_comb begin
        lwstall_cnt_d = lwstall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (lw_stall_eff && (lwstall_cnt_q != '1)) begin
            lwstall_cnt_d = lwstall_cnt_q + CNT_W'(1);
        end
        if (PCSrcE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset leaves a bubble in Execute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q      <= '0;
            lwstall_cnt_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            bundle_q      <= bundle_d;
            lwstall_cnt_q <= lwstall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign Rs1E        = bundle_q.rs1;
    assign Rs2E        = bundle_q.rs2;
    assign RdE         = bundle_q.rd;
    assign RD1E        = bundle_q.rd1;
    assign RD2E        = bundle_q.rd2;
    assign ImmExtE     = bundle_q.imm;
    assign PCE         = bundle_q.pc;
    assign PCPlus4E    = bundle_q.pc_plus4;
    assign RegWriteE   = bundle_q.reg_write;
    assign MemWriteE   = bundle_q.mem_write;
    assign ALUSrcE     = bundle_q.alu_src;
    assign JumpE       = bundle_q.jump;
    assign BranchE     = bundle_q.branch;
    assign ValidE      = bundle_q.valid;
    assign ResultSrcE  = bundle_q.result_src;
    assign ALUControlE = bundle_q.alu_control;
    assign StallF      = lw_stall_eff;
    assign StallD      = lw_stall_eff;
    assign FlushD      = PCSrcE;
    assign FlushE      = flush_e;
    assign lwstall_cnt = lwstall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the stimulus process pushes the expected
// per-cycle view (E register contents, stall/flush lines, counters) and a
// monitor pops and compares it on the falling edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [10:0] ctl; // RegWrite MemWrite ALUSrc Jump Branch Valid ResultSrc[1:0] ALUCtl[2:0]
    } ex_t;

    typedef struct packed {
        ex_t        e;
        logic       stall;
        logic       flushd;
        logic       flushe;
        logic [3:0] lw;
        logic [3:0] fl;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  Rs1D = '0, Rs2D = '0, RdD = '0;
    logic [31:0] RD1D = '0, RD2D = '0, ImmExtD = '0, PCD = '0, PCPlus4D = '0;
    logic        RegWriteD = 1'b0, MemWriteD = 1'b0, ALUSrcD = 1'b0, JumpD = 1'b0;
    logic        BranchD = 1'b0, ValidD = 1'b0, PCSrcE = 1'b0;
    logic [1:0]  ResultSrcD = '0;
    logic [2:0]  ALUControlD = '0;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [3:0]  lwstall_cnt, flush_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    rec_t sb_q[$];
    ex_t  model_e = '0;
    logic [3:0] model_lw = '0;
    logic [3:0] model_fl = '0;

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .JumpD(JumpD), .BranchD(BranchD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .ValidD(ValidD), .PCSrcE(PCSrcE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
        .JumpE(JumpE), .BranchE(BranchE), .ValidE(ValidE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .lwstall_cnt(lwstall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Build a full Decode bundle; secondary fields are derived from rd1 so
    // every vector exercises distinct data on every field.
    function automatic ex_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [1:0] rsrc,
                               input logic regw, input logic [31:0] rd1);
        ex_t d;
        d.rs1 = rs1;
        d.rs2 = rs2;
        d.rd  = rd;
        d.rd1 = rd1;
        d.rd2 = rd1 ^ 32'h0000_ffff;
        d.imm = rd1 + 32'd1;
        d.pc  = {rd1[29:0], 2'b00};
        d.pc4 = {rd1[29:0], 2'b00} + 32'd4;
        d.ctl = {regw, ~regw, rd1[8], rd1[9], rd1[10], 1'b1, rsrc, rd1[6:4]};
        return d;
    endfunction

    // One cycle: drive Decode, push the expected view for this cycle, then
    // advance the bench's E-register and counter expectations.
    task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [1:0] rsrc, input logic regw,
                        input logic [31:0] rd1, input logic pcsrc,
                        input logic xstall, input logic xflushe);
        ex_t  d;
        rec_t r;
        @(posedge clk);
        #1;
        d = mk(rs1, rs2, rd, rsrc, regw, rd1);
        rst_n = ~rst;
        Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
        RD1D = d.rd1; RD2D = d.rd2; ImmExtD = d.imm; PCD = d.pc; PCPlus4D = d.pc4;
        {RegWriteD, MemWriteD, ALUSrcD, JumpD, BranchD, ValidD, ResultSrcD, ALUControlD} = d.ctl;
        PCSrcE = pcsrc;
        if (rst) begin
            model_e  = '0;
            model_lw = '0;
            model_fl = '0;
        end
        r.e      = model_e;
        r.stall  = xstall;
        r.flushd = pcsrc;
        r.flushe = xflushe;
        r.lw     = model_lw;
        r.fl     = model_fl;
        sb_q.push_back(r);
        if (!rst) begin
            model_e = xflushe ? '0 : d;
            if (xstall && model_lw != 4'hf) model_lw = model_lw + 4'd1;
            if (pcsrc && model_fl != 4'hf) model_fl = model_fl + 4'd1;
        end
    endtask

    // Monitor: compare every pushed expectation against the DUT mid-cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                r = sb_q.pop_front();
                chk("Rs1E", 32'(Rs1E), 32'(r.e.rs1));
                chk("Rs2E", 32'(Rs2E), 32'(r.e.rs2));
                chk("RdE", 32'(RdE), 32'(r.e.rd));
                chk("RD1E", RD1E, r.e.rd1);
                chk("RD2E", RD2E, r.e.rd2);
                chk("ImmExtE", ImmExtE, r.e.imm);
                chk("PCE", PCE, r.e.pc);
                chk("PCPlus4E", PCPlus4E, r.e.pc4);
                chk("ctrlE", 32'({RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, ValidE,
                                  ResultSrcE, ALUControlE}), 32'(r.e.ctl));
                chk("StallF", 32'(StallF), 32'(r.stall));
                chk("StallD", 32'(StallD), 32'(r.stall));
                chk("FlushD", 32'(FlushD), 32'(r.flushd));
                chk("FlushE", 32'(FlushE), 32'(r.flushe));
                chk("lwstall_cnt", 32'(lwstall_cnt), 32'(r.lw));
                chk("flush_cnt", 32'(flush_cnt), 32'(r.fl));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   rst rs1 rs2 rd  rsrc regw rd1           pcsrc stall flushE
        // Reset held with busy Decode inputs: E stays a bubble.
        step(1, 5'd9, 5'd10, 5'd11, 2'b01, 1, 32'hdead_beef, 0, 0, 0);
        step(1, 5'd9, 5'd10, 5'd11, 2'b01, 1, 32'hdead_beef, 0, 0, 0);
        // Release; first edge captures RdD=5, RD1D=0x1234.
        step(0, 5'd1, 5'd2, 5'd5, 2'b00, 1, 32'h0000_1234, 0, 0, 0);
        // Load x7, then a dependent on rs1=7: one stall cycle, bubble, replay.
        step(0, 5'd3, 5'd4, 5'd7, 2'b01, 1, 32'h0000_0100, 0, 0, 0);
        step(0, 5'd7, 5'd8, 5'd9, 2'b00, 1, 32'h0000_0200, 0, 1, 1);
        step(0, 5'd7, 5'd8, 5'd9, 2'b00, 1, 32'h0000_0200, 0, 0, 0);
        step(0, 5'd10, 5'd11, 5'd12, 2'b00, 1, 32'h0000_0300, 0, 0, 0);
        // Load to x0 followed by a reader of x0: never a stall.
        step(0, 5'd0, 5'd0, 5'd0, 2'b01, 1, 32'h0000_0400, 0, 0, 0);
        step(0, 5'd0, 5'd0, 5'd13, 2'b00, 1, 32'h0000_0500, 0, 0, 0);
        // Taken branch: FlushD/FlushE, then a bubble in E.
        step(0, 5'd1, 5'd2, 5'd14, 2'b00, 0, 32'h0000_0600, 1, 0, 1);
        step(0, 5'd3, 5'd4, 5'd15, 2'b00, 1, 32'h0000_0700, 0, 0, 0);
        // Load x6 then rs2=6 reader while PCSrcE fires: flush wins, no stall count.
        step(0, 5'd1, 5'd2, 5'd6, 2'b01, 1, 32'h0000_0800, 0, 0, 0);
        step(0, 5'd1, 5'd6, 5'd16, 2'b00, 1, 32'h0000_0900, 1, 0, 1);
        step(0, 5'd1, 5'd2, 5'd17, 2'b00, 1, 32'h0000_0a00, 0, 0, 0);
        // Plain load-use through rs2.
        step(0, 5'd1, 5'd2, 5'd20, 2'b01, 1, 32'h0000_0b00, 0, 0, 0);
        step(0, 5'd3, 5'd20, 5'd21, 2'b00, 1, 32'h0000_0c00, 0, 1, 1);
        step(0, 5'd3, 5'd20, 5'd21, 2'b00, 1, 32'h0000_0c00, 0, 0, 0);
        // 20 back-to-back flushes: 4-bit flush counter pins at 15.
        for (int i = 0; i < 20; i++) begin
            step(0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 32'(i), 1, 0, 1);
        end
        step(0, 5'd1, 5'd2, 5'd3, 2'b00, 1, 32'h0000_0d00, 0, 0, 0);
        step(0, 5'd1, 5'd2, 5'd4, 2'b00, 1, 32'h0000_0e00, 0, 0, 0);
        // Reset mid-operation clears everything at once; then normal capture.
        step(1, 5'd5, 5'd6, 5'd7, 2'b01, 1, 32'h0000_0f00, 0, 0, 0);
        step(0, 5'd5, 5'd6, 5'd8, 2'b00, 1, 32'h0000_1000, 0, 0, 0);
        step(0, 5'd1, 5'd1, 5'd1, 2'b00, 1, 32'h0000_1100, 0, 0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection and branch/jump flush control.
- Captures decoded operands, register indices and control bits in Decode and presents them to Execute.
- Rs1E/Rs2E/RdE feed the EX-stage forwarding logic.
- Also drives the Fetch/Decode stall and flush lines, and keeps two saturating hazard counters for performance monitoring.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- CNT_W, 16, width of each saturating hazard counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Rs1D, Rs2D, RdD  input  5 each  register indices of the instruction in Decode.
- RD1D, RD2D  input  XLEN each  register-file read data.
- ImmExtD  input  XLEN  sign-extended immediate.
- PCD, PCPlus4D  input  XLEN each  PC of the Decode instruction and PC+4.
- RegWriteD, MemWriteD, ALUSrcD, JumpD, BranchD  input  1 each  decoded control.
- ResultSrcD  input  2  00 ALU, 01 load data, 10 PC+4.
- ALUControlD  input  3  ALU operation.
- ValidD  input  1  Decode holds a real instruction.
- PCSrcE  input  1  branch taken or jump in Execute, this cycle.
- Rs1E, Rs2E, RdE  output  5 each  registered indices.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  XLEN each  registered data.
- RegWriteE, MemWriteE, ALUSrcE, JumpE, BranchE, ValidE  output  1 each  registered control.
- ResultSrcE  output  2  registered control.
- ALUControlE  output  3  registered control.
- StallF, StallD  output  1 each  hold the PC register and the IF/ID register.
- FlushD  output  1  bubble the IF/ID register.
- FlushE  output  1  internal bubble of this register, exported for debug.
- lwstall_cnt, flush_cnt  output  CNT_W each  hazard counters.

Behaviour:
- Reset: rst_n low asynchronously clears every registered output and both counters to 0. Result is a bubble: ValidE=0, RegWriteE=0, MemWriteE=0.
- Load-use detect (combinational): lwStall = (ResultSrcE==2'b01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
  - Comparison is conservative: it ignores whether the instruction actually reads rs1/rs2.
- Stall and flush outputs (all combinational):
  - StallF = StallD = lwStall & ~PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- Register update on each rising clk:
  - If FlushE: all control outputs (RegWrite, MemWrite, ResultSrc, ALUControl, ALUSrc, Jump, Branch, Valid) load 0. RdE, Rs1E, Rs2E load 0. Data fields load 0.
  - Otherwise: all *E outputs load their *D inputs.
- Latency: exactly one cycle D→E; no backpressure beyond FlushE.
- Simultaneous lwStall and PCSrcE: PCSrcE dominates.
  - Stall is suppressed, so the front end redirects.
  - FlushD and FlushE are both asserted.
  - Only flush_cnt increments.
- lwstall_cnt increments by 1 on each clk edge where lwStall & ~PCSrcE; saturates at all-ones.
- flush_cnt increments by 1 on each clk edge where PCSrcE; saturates at all-ones.
- A stalled Decode instruction is re-presented next cycle. After the bubble, ResultSrcE≠01, so lwStall deasserts. Stall length is exactly 1 cycle per load-use pair.
- RdE==0 never causes a stall, even for a load to x0.
- Reset asserted mid-operation overrides everything. First edge after deassert captures the D inputs normally.

Test Plan:
- Reset: hold rst_n=0 with all D inputs nonzero → all E outputs 0, counters 0, StallF=0. Release, apply RdD=5, RD1D=0x1234 → next cycle RdE=5, RD1E=0x1234, ValidE=1.
- Load-use: cycle N load with RdD=7, ResultSrcD=01. Cycle N+1 Decode Rs1D=7 → StallF=StallD=FlushE=1 for one cycle. Cycle N+2 E outputs are a bubble (ValidE=0, RegWriteE=0). Cycle N+3 the dependent instruction appears in E with Rs1E=7. lwstall_cnt=1.
- Load to x0: RdE=0, ResultSrcE=01, Rs1D=0 → no stall, lwstall_cnt unchanged.
- Branch flush: PCSrcE=1 for one cycle → FlushD=1, FlushE=1, StallF=0. Next E is a bubble. flush_cnt=1.
- Simultaneous: load-use condition and PCSrcE=1 in the same cycle → StallF=0, FlushD=1. flush_cnt +1, lwstall_cnt unchanged.
- Saturation: with CNT_W=4, 20 consecutive PCSrcE cycles → flush_cnt stops at 15 and stays there.
